// File: rtl/sm_pkg.sv
// Shared types for the sign-magnitude stream accumulator: FSM state and
// the sign-normalisation helper used wherever a magnitude may be zero.
package sm_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } sm_state_t;

    // A zero magnitude always carries a positive sign (no -0 anywhere).
    function automatic logic sm_norm(input logic sign, input logic mag_zero);
        return sign & ~mag_zero;
    endfunction

endpackage

// File: rtl/sm_add_core.sv
// Combinational W-bit sign-magnitude adder: compare, add or subtract,
// normalise zero to +0. Carry is the overflow of the (W-1)-bit magnitude add.
module sm_add_core
    import sm_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         i_a_sign,
    input  logic [W-2:0] i_a_mag,
    input  logic         i_b_sign,
    input  logic [W-2:0] i_b_mag,
    output logic         o_sign,
    output logic [W-2:0] o_mag,
    output logic         o_carry
);

    logic [W-1:0] w_sum;
    logic         w_a_ge_b;
    logic         w_sign_raw;
    logic [W-2:0] w_mag_raw;

    assign w_a_ge_b = (i_a_mag >= i_b_mag);

    always_comb begin
        w_sum      = '0;
        w_sign_raw = i_a_sign;
        w_mag_raw  = '0;
        o_carry    = 1'b0;
        if (i_a_sign == i_b_sign) begin
            w_sum     = {1'b0, i_a_mag} + {1'b0, i_b_mag};
            w_mag_raw = w_sum[W-2:0];
            o_carry   = w_sum[W-1];
        end else if (w_a_ge_b) begin
            w_mag_raw  = i_a_mag - i_b_mag;
            w_sign_raw = i_a_sign;
        end else begin
            w_mag_raw  = i_b_mag - i_a_mag;
            w_sign_raw = i_b_sign;
        end
    end

    // Equal magnitudes of opposite sign land here with a zero magnitude.
    assign o_mag  = w_mag_raw;
    assign o_sign = sm_norm(w_sign_raw, (w_mag_raw == '0));

endmodule

// File: rtl/sm_accum.sv
// Framed sign-magnitude stream accumulator with per-frame result and sticky
// overflow. Define SM_ACCUM_SAT_EN for saturating magnitude; default wraps.
module sm_accum
    import sm_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_sub,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_data,
    output logic         out_ovf
);

    localparam int MW = M - 1;

    sm_state_t     r_state;
    sm_state_t     w_state_nxt;
    logic          r_acc_sign;
    logic [M-2:0]  r_acc_mag;
    logic          r_ovf;
    logic [M-1:0]  r_out_data;
    logic          r_out_ovf;

    logic          w_accept;
    logic          w_op_sign;
    logic [M-2:0]  w_op_mag;
    logic          w_sum_sign;
    logic [M-2:0]  w_sum_mag;
    logic          w_carry;
    logic [M-2:0]  w_new_mag;
    logic          w_new_ovf;

    assign w_accept  = in_valid && (r_state == ACC);
    assign w_op_mag  = MW'(in_data[N-2:0]);
    assign w_op_sign = sm_norm(in_data[N-1] ^ in_sub, (in_data[N-2:0] == '0));

    sm_add_core #(.W(M)) u_add_core (
        .i_a_sign (r_acc_sign),
        .i_a_mag  (r_acc_mag),
        .i_b_sign (w_op_sign),
        .i_b_mag  (w_op_mag),
        .o_sign   (w_sum_sign),
        .o_mag    (w_sum_mag),
        .o_carry  (w_carry)
    );

`ifdef SM_ACCUM_SAT_EN
    // Clamp keeps the sign; the clamped value is never zero, so no renormalise.
    assign w_new_mag = w_carry ? '1 : w_sum_mag;
`else
    assign w_new_mag = w_sum_mag;
`endif
    assign w_new_ovf = r_ovf | w_carry;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC: if (w_accept && in_last) w_state_nxt = OUT;
            OUT: if (out_ready)           w_state_nxt = ACC;
            default:                      w_state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_sign <= 1'b0;
            r_acc_mag  <= '0;
            r_ovf      <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_out_data <= {w_sum_sign, w_new_mag};
                r_out_ovf  <= w_new_ovf;
                r_acc_sign <= 1'b0;
                r_acc_mag  <= '0;
                r_ovf      <= 1'b0;
            end else begin
                r_acc_sign <= w_sum_sign;
                r_acc_mag  <= w_new_mag;
                r_ovf      <= w_new_ovf;
            end
        end
    end

    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == OUT);
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sm_accum.sv
// Self-checking bench for sm_accum (N=8, M=12): table of single-beat frames,
// hand-written multi-cycle sequences, and random frames against a value model.
module tb_sm_accum;

    localparam int N = 8;
    localparam int M = 12;
    localparam int MAXMAG = (1 << (M - 1)) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         in_sub = 1'b0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [M-1:0] out_data;
    logic         out_ovf;

    int checks = 0;
    int errors = 0;

    sm_accum #(.N(N), .M(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic sub, input logic last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("beat_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0; in_sub = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [11:0] exp_d, input logic exp_o);
        int n = 0;
        @(negedge clk);
        chk({name, "_lat"}, 32'(out_valid), 32'd1);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_data"}, 32'(out_data), 32'(exp_d));
        chk({name, "_ovf"}, 32'(out_ovf), 32'(exp_o));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    // Reference: signed integer value, overflow when |value| exceeds the range.
    task automatic model_step(inout int val, inout bit ovf, input logic [7:0] d, input logic sub);
        int op;
        int sum;
        int mag;
        op  = int'(d[6:0]);
        if (d[7] ^ sub) op = -op;
        sum = val + op;
        mag = (sum < 0) ? -sum : sum;
        if (mag > MAXMAG) begin
            ovf = 1'b1;
`ifdef SM_ACCUM_SAT_EN
            mag = MAXMAG;
`else
            mag = mag % (MAXMAG + 1);
`endif
        end
        val = (sum < 0) ? -mag : mag;
    endtask

    function automatic logic [11:0] to_sm(input int val);
        logic [11:0] r;
        r = (val < 0) ? {1'b1, 11'(-val)} : {1'b0, 11'(val)};
        return r;
    endfunction

    typedef struct {
        logic [7:0]  d;
        logic        sub;
        logic [11:0] exp_d;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [11:0] exp_ovf_data;
        int          val;
        bit          ovf;
        int          len;
        logic [7:0]  d;
        logic        sub;

        tbl[0] = '{8'h85, 1'b1, 12'h005};
        tbl[1] = '{8'h80, 1'b0, 12'h000};
        tbl[2] = '{8'h00, 1'b1, 12'h000};
        tbl[3] = '{8'h7F, 1'b0, 12'h07F};
        tbl[4] = '{8'hFF, 1'b0, 12'h87F};
        tbl[5] = '{8'h01, 1'b1, 12'h801};

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            beat(tbl[i].d, tbl[i].sub, 1'b1);
            get_result($sformatf("tbl%0d", i), tbl[i].exp_d, 1'b0);
        end

        beat(8'h05, 1'b0, 1'b0);
        beat(8'h83, 1'b0, 1'b0);
        beat(8'h0A, 1'b0, 1'b1);
        get_result("mixed", 12'h00C, 1'b0);

        beat(8'h07, 1'b0, 1'b0);
        beat(8'h87, 1'b0, 1'b1);
        get_result("cancel", 12'h000, 1'b0);

`ifdef SM_ACCUM_SAT_EN
        exp_ovf_data = 12'h7FF;
`else
        exp_ovf_data = 12'h06F;
`endif
        for (int i = 0; i < 17; i++) beat(8'h7F, 1'b0, (i == 16));
        get_result("ovf", exp_ovf_data, 1'b1);
        beat(8'h01, 1'b0, 1'b1);
        get_result("post_ovf", 12'h001, 1'b0);

        beat(8'h11, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'h22; in_last = 1'b1;
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'h011);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        get_result("bp", 12'h011, 1'b0);
        beat(8'h01, 1'b0, 1'b1);
        get_result("bp_next", 12'h001, 1'b0);

        beat(8'h10, 1'b0, 1'b0);
        beat(8'h20, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("amid_in_ready", 32'(in_ready), 32'd1);
        chk("amid_out_valid", 32'(out_valid), 32'd0);
        chk("amid_out_data", 32'(out_data), 32'd0);
        #10;
        reset = 1'b0;
        beat(8'h01, 1'b0, 1'b1);
        get_result("after_rst", 12'h001, 1'b0);

        for (int f = 0; f < 40; f++) begin
            val = 0;
            ovf = 1'b0;
            len = int'($urandom_range(1, 24));
            for (int b = 0; b < len; b++) begin
                d   = 8'($urandom);
                sub = 1'($urandom);
                if (f % 4 == 0) d = {1'b0, 7'($urandom_range(100, 127))};
                if (f % 4 == 0) sub = 1'b0;
                model_step(val, ovf, d, sub);
                beat(d, sub, (b == len - 1));
            end
            get_result($sformatf("rnd%0d", f), to_sm(val), ovf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
